// File: rtl/i2c_master_write_byte.sv
// Master-side I2C byte transmitter. It sends one latched byte MSB-first
// on eight SCL pulses, releases SDA for a ninth pulse to sample the
// slave's ACK, and then pulses finish. START/STOP and bus muxing belong
// to the surrounding controller.
module i2c_master_write_byte #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] data_in,
    input  logic       sda_i,
    output logic       scl,
    output logic       sda_o,
    output logic       finish,
    output logic       ack_ok
);

    localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        ACK   = 3'd2,
        DONE  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            scl_q, scl_d;
    logic            sda_o_q, sda_o_d;
    logic            finish_q, finish_d;
    logic            ack_ok_q, ack_ok_d;

    // Bit-period timing helpers: last clock of a quarter, next phase, end of a bit.
    logic       q_last;
    logic [1:0] nphase;
    logic       bit_end;

    assign q_last  = (qcnt_q == QW'(CLK_DIV - 1));
    assign nphase  = q_last ? 2'(phase_q + 2'd1) : phase_q;
    assign bit_end = q_last && (phase_q == 2'd3);

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            scl_q     <= 1'b0;
            sda_o_q   <= 1'b1;
            finish_q  <= 1'b0;
            ack_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            scl_q     <= scl_d;
            sda_o_q   <= sda_o_d;
            finish_q  <= finish_d;
            ack_ok_q  <= ack_ok_d;
        end
    end

    // Next-state and next-output logic; SDA only moves at the start of phase 0.
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        scl_d     = scl_q;
        sda_o_d   = sda_o_q;
        finish_d  = 1'b0;
        ack_ok_d  = ack_ok_q;

        case (state_q)
            IDLE: begin
                scl_d   = 1'b0;
                sda_o_d = 1'b1;
                qcnt_d  = '0;
                phase_d = '0;
                if (go) begin
                    shift_d   = data_in;
                    bit_cnt_d = 3'd7;
                    ack_ok_d  = 1'b0;
                    sda_o_d   = data_in[7];
                    state_d   = SHIFT;
                end
            end

            SHIFT, ACK: begin
                if (!go) begin
                    // Abort: drop the bus back to idle levels without finishing.
                    state_d = IDLE;
                    scl_d   = 1'b0;
                    sda_o_d = 1'b1;
                    qcnt_d  = '0;
                    phase_d = '0;
                end else begin
                    qcnt_d  = q_last ? '0 : QW'(qcnt_q + QW'(1));
                    phase_d = nphase;
                    scl_d   = nphase[1];
                    if (state_q == SHIFT) begin
                        if (bit_end) begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = 3'(bit_cnt_q - 3'd1);
                            if (bit_cnt_q == 3'd0) begin
                                state_d = ACK;
                                sda_o_d = 1'b1;
                            end else begin
                                sda_o_d = shift_q[6];
                            end
                        end
                    end else begin
                        if (q_last && (phase_q == 2'd2)) begin
                            ack_ok_d = ~sda_i;
                        end
                        if (bit_end) begin
                            state_d  = DONE;
                            finish_d = 1'b1;
                            scl_d    = 1'b0;
                            sda_o_d  = 1'b1;
                        end
                    end
                end
            end

            DONE: begin
                scl_d   = 1'b0;
                sda_o_d = 1'b1;
                state_d = HOLD;
            end

            HOLD: begin
                scl_d   = 1'b0;
                sda_o_d = 1'b1;
                if (!go) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                scl_d   = 1'b0;
                sda_o_d = 1'b1;
            end
        endcase
    end

    assign scl    = scl_q;
    assign sda_o  = sda_o_q;
    assign finish = finish_q;
    assign ack_ok = ack_ok_q;

endmodule

// File: doc/i2c_master_write_byte.md
# i2c_master_write_byte

Master-side byte transmitter for the I2C controller: the transmit counterpart of the master byte reader. On `go`, it latches a parallel byte and shifts it onto SDA MSB-first over eight generated SCL pulses. It releases SDA for a ninth pulse, samples the slave's ACK, and pulses `finish`. The block runs only between START and STOP; the top-level controller muxes its `scl`/`sda_o` onto the bus and owns START/STOP generation.

## Interface
- `CLK_DIV`, default 4: system clocks per SCL quarter-period; legal range ≥1. One SCL period is 4·CLK_DIV clocks.
- `clock` input 1: single system clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `go` input 1: level request from the controller; held high until `finish` is seen.
- `data_in` input 8: byte to transmit; sampled only on the accept cycle.
- `sda_i` input 1: synchronized SDA bus level, used for ACK sampling.
- `scl` output 1: SCL drive value.
- `sda_o` output 1: SDA drive value; 0 pulls low, 1 releases.
- `finish` output 1: one-clock pulse at transfer completion.
- `ack_ok` output 1: 1 means the slave ACKed (SDA low at the 9th sample).

## Operation
- Reset values: `scl`=0, `sda_o`=1, `finish`=0, `ack_ok`=0, state IDLE, all counters 0.
- States:
  - IDLE: `scl`=0, `sda_o`=1. On `go`=1, latch `data_in` into the shift register, set bit counter=7, clear `ack_ok`, go to SHIFT.
  - SHIFT: transmit bits 7..0, one SCL period per bit.
  - ACK: one SCL period with `sda_o`=1.
  - DONE: assert `finish` for exactly one clock, then go to HOLD.
  - HOLD: wait for `go`=0, then go to IDLE. This prevents retrigger while the controller still holds `go`.
- Bit period: a quarter counter runs 0..CLK_DIV-1 and a phase counter runs 0..3. Phases 0–1 have `scl`=0, phases 2–3 have `scl`=1.
  - `sda_o` updates only at the first clock of phase 0, so SDA never changes while SCL is high.
  - In SHIFT, `sda_o` = current MSB of the shift register; the register shifts left at the end of phase 3.
  - The bit counter decrements at the end of each SHIFT bit. After bit 0 completes, go to ACK.
- ACK sampling: `sda_i` is sampled at the last clock of phase 2 of the ACK period, and `ack_ok` = ~`sda_i`. `ack_ok` holds until the next accept or reset.
- Abort: if `go` falls during SHIFT or ACK, return to IDLE on the next clock with `scl`=0 and `sda_o`=1. `finish` is not asserted and `ack_ok` is unchanged.
- Asynchronous reset mid-transfer returns immediately to reset values.
- `data_in` changes after the accept cycle have no effect.

## Timing
- Accept: `go` is seen high in IDLE at edge k; `sda_o` shows bit 7 from edge k+1.
- Per bit: 4·CLK_DIV clocks. SCL rises 2·CLK_DIV clocks after the bit starts.
- Total: the first SHIFT clock is k+1 and the last ACK clock is k+36·CLK_DIV. `finish` is high during cycle k+36·CLK_DIV+1 only.
- `ack_ok` is valid in the same cycle `finish` is high.
- HOLD→IDLE takes one clock after `go`=0 is sampled. The earliest next accept is 2 clocks after `go` falls and rises again.
- At CLK_DIV=1, the quarter counter is a constant 0 and each phase lasts one clock; timing stays exact.

## Test plan
- CLK_DIV=4, `data_in`=8'hA5, slave model drives `sda_i`=0 during the ACK high phase:
  - Bench decodes SDA at each SCL rising edge and gets 1,0,1,0,0,1,0,1.
  - `finish` pulses at clock 145 after accept; `ack_ok`=1.
- `data_in`=8'h3C, `sda_i` left high (no slave) -> bits 0,0,1,1,1,1,0,0 on the bus; `finish` pulses; `ack_ok`=0.
- CLK_DIV=1, `data_in`=8'hFF, `go` held high 100 clocks after `finish` -> exactly one `finish`, at clock 37 after accept; no second transfer until `go` drops and rises.
- `go` dropped during bit 4 -> next clock `scl`=0, `sda_o`=1, state IDLE; no `finish`; a new `go` with 8'h81 transfers cleanly.
- `reset` asserted asynchronously mid-SCL-high in bit 2 -> outputs go to reset values within the same cycle with no clock needed; a transfer after reset completes normally.
- Protocol checker across all of the above: `sda_o` never changes while `scl`=1; `scl` high and low widths are each exactly 2·CLK_DIV clocks.
